// File: rtl/fft008_in_buf.sv
// Frames a valid/ready sample stream into 8-sample parallel frames for fft008 (FFT_IN_PRESCALE_EN: halve each sample half).
// Latency: 8th accept at edge T sets buf_full; frame published at T+1 when the output stage is free.
// Backpressure: s_ready is registered (!buf_full); a stalled frame plus one full fill buffer stop input.
module fft008_in_buf (
  input  logic        ck,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [31:0] s_data,
  output logic [31:0] xo_000,
  output logic [31:0] xo_001,
  output logic [31:0] xo_002,
  output logic [31:0] xo_003,
  output logic [31:0] xo_004,
  output logic [31:0] xo_005,
  output logic [31:0] xo_006,
  output logic [31:0] xo_007,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [7:0]  frm_seq,
  output logic        err_resync
);

  logic [2:0]       wr_cnt;
  logic             buf_full;
  logic [7:0][31:0] fill_buf;
  logic [7:0][31:0] xo_q;
  logic [31:0]      s_store;
  logic [2:0]       idx;
  logic             accept;
  logic             publish;

`ifdef FFT_IN_PRESCALE_EN
  assign s_store = {s_data[31], s_data[31:17], s_data[15], s_data[15:1]};
`else
  assign s_store = s_data;
`endif

  assign s_ready = !buf_full;
  assign accept  = s_valid && s_ready;
  assign publish = buf_full && (!frm_valid || frm_ready);
  assign idx     = s_sof ? 3'd0 : wr_cnt;

  // accept and publish are mutually exclusive: accept needs !buf_full, publish needs buf_full
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_cnt     <= 3'd0;
      buf_full   <= 1'b0;
      frm_valid  <= 1'b0;
      frm_seq    <= 8'd0;
      err_resync <= 1'b0;
      xo_q       <= '0;
    end else begin
      if (accept) begin
        wr_cnt <= idx + 3'd1;
        if (idx == 3'd7) buf_full <= 1'b1;
        if (s_sof && (wr_cnt != 3'd0)) err_resync <= 1'b1;
      end
      if (publish) begin
        xo_q      <= fill_buf;
        frm_valid <= 1'b1;
        buf_full  <= 1'b0;
        frm_seq   <= frm_seq + 8'd1;
      end else if (frm_valid && frm_ready) begin
        frm_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!rst && accept) fill_buf[idx] <= s_store;
  end

  assign xo_000 = xo_q[0];
  assign xo_001 = xo_q[1];
  assign xo_002 = xo_q[2];
  assign xo_003 = xo_q[3];
  assign xo_004 = xo_q[4];
  assign xo_005 = xo_q[5];
  assign xo_006 = xo_q[6];
  assign xo_007 = xo_q[7];

endmodule

// File: doc/fft008_in_buf.md
# fft008_in_buf

Input framing stage for the 8-point FFT core `fft008`. It accepts complex samples one per handshake on a valid/ready stream and assembles them into 8-sample frames in natural order. Each complete frame is presented on eight parallel 32-bit buses `xo_000`..`xo_007`, which wire directly to `xi_000`..`xi_007` of `fft008`. Frames are released under a valid/ready handshake, so a consumer can stall the stream. A fill buffer plus an output holding register give one frame of double buffering.

## Interface
Parameters: none (frame size fixed at 8, sample width fixed at 32).

- `ck`  in  1  clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  block can accept a sample
- `s_sof`  in  1  start-of-frame marker, qualified by accept
- `s_data`  in  32  complex sample {re[31:16], im[15:0]}, 2's complement Q4.11
- `xo_000`..`xo_007`  out  32 each  published frame, index n = n-th accepted sample
- `frm_valid`  out  1  `xo_*` holds an unconsumed frame
- `frm_ready`  in  1  consumer takes the frame
- `frm_seq`  out  8  count of frames published, wraps 255->0
- `err_resync`  out  1  sticky: a partial frame was discarded by `s_sof`

## Operation
- Accept: `s_valid && s_ready` at a posedge.
- Transfer: `frm_valid && frm_ready` at a posedge.
- State:
  - `wr_cnt[2:0]`: next fill index.
  - `buf_full`: fill buffer holds 8 samples.
  - `buf[0..7]`: fill buffer.
  - Output registers `xo_*`.
  - `frm_valid`.
- `s_ready = !buf_full`. This is a registered flag only, with no combinational path from `frm_ready`.
- On accept:
  - Store the sample (pre-scaled, see Configuration) at `buf[idx]`.
  - `idx = 0` if `s_sof`, else `wr_cnt`.
  - Then `wr_cnt <= idx+1`.
  - If `idx == 7`, set `buf_full <= 1`; `wr_cnt` wraps to 0.
- Resync: on accept with `s_sof=1` and `wr_cnt != 0`:
  - Samples already in the partial frame are discarded.
  - `err_resync <= 1`.
  - `s_sof` with `wr_cnt == 0` is legal and silent.
- Publish: when `buf_full && (!frm_valid || frm_ready)`:
  - `xo_n <= buf[n]` for all n.
  - `frm_valid <= 1`, `buf_full <= 0`, `frm_seq <= frm_seq+1`.
- Consume without refill: if `frm_valid && frm_ready && !buf_full`, then `frm_valid <= 0`. `xo_*` keep their last value; they are never cleared except by reset.
- Simultaneous consume and publish: `frm_valid` stays 1 and `xo_*` load the new frame.
- `xo_*` change only on publish.
- `buf` entries are don't-care when not full.
- Reset, including mid-frame:
  - `wr_cnt=0`, `buf_full=0`, `frm_valid=0`, `frm_seq=0`, `err_resync=0`, all `xo_*=0`.
  - `s_ready=1` in the first cycle after reset deasserts.
  - The partial frame is lost without flagging an error.
- Inputs during `rst` are ignored.

## Timing
- Latency: 8th sample accepted at edge T gives `buf_full=1` after T. Publish at edge T+1 if the output stage is free; `frm_valid` and the new `xo_*` are visible after T+1.
- Throughput: one frame per 9 cycles at full input rate, because `s_ready` drops for one cycle per frame.
- Back-pressure: with `frm_valid=1` and `frm_ready=0`, at most 8 further samples are accepted. `s_ready` then holds 0 until the frame is taken.
- `fft008` registers its inputs every clock and has 2-cycle latency (input reg + output reg). The consumer samples `fo_*` 2 cycles after its transfer edge. The frame must stay stable until that consumer transfer; this is guaranteed, since `xo_*` change only on publish.

## Configuration
- `FFT_IN_PRESCALE_EN` defined: each half of `s_data` is arithmetic-shifted right by 1 (sign-extended, truncation toward -inf) before storage. This adds one bit of headroom against the 3-bit growth of the 8-point butterfly.
- Undefined: samples are stored unmodified.
- Ports and timing are identical in both builds.

## Test plan
- Reset, then 8 accepts of `{16'hn, 16'h0}` (n=1..8), `frm_ready=1`:
  - `frm_valid` rises 1 cycle after the 8th accept.
  - `xo_000=32'h00010000` … `xo_007=32'h00080000`.
  - `frm_seq=1`.
  - `s_ready` low exactly 1 cycle.
- Continuous stream of 3 frames with `frm_ready=1`: frames publish every 9 cycles, `frm_seq` reads 1, 2, 3, `err_resync=0`.
- `frm_ready=0` with 20 samples offered:
  - Exactly 16 accepted; `s_ready=0` thereafter.
  - After `frm_ready` pulses once, `xo_*` switch to frame 2 in the same edge and `frm_valid` stays 1.
- 3 samples accepted, then `s_sof=1` with `32'hAAAA5555`: `err_resync=1`, next published `xo_000=32'hAAAA5555`, 7 more samples complete the frame.
- `rst` asserted after 5 samples: all outputs 0 next cycle; a following clean 8-sample frame publishes with `frm_seq=1`, `err_resync=0`.
- `FFT_IN_PRESCALE_EN` build, input `32'hF55A0A66`: stored `xo_000=32'hFAAD0533`.
